// File: rtl/trackball_pkg.sv
// Shared encodings for the trackball quadrature/step generator: speed and
// mode codes, field widths and the quadrature Gray table.
package trackball_pkg;

    typedef enum logic [1:0] {
        SPEED_QTR  = 2'd0,
        SPEED_HALF = 2'd1,
        SPEED_X1   = 2'd2,
        SPEED_X2   = 2'd3
    } speed_e;

    typedef enum logic {
        MODE_CLKDIR = 1'b0,
        MODE_QUAD   = 1'b1
    } mode_e;

    localparam int DELTA_W  = 9;
    // Holds +/-512: a full-scale delta doubled at SPEED_X2.
    localparam int SCALED_W = 11;

    // Phase 0..3 -> {A,B}; consecutive phases differ in exactly one bit.
    function automatic logic [1:0] quad_ab(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b01;
            2'd2:    ab = 2'b11;
            default: ab = 2'b10;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/trackball_axis.sv
// One motion axis: scales incoming deltas into a saturating accumulator and
// drains it one unit per STEP_DIV cycles, emitting clock/direction or quadrature.
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 3000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      delta_valid,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic [1:0]                speed,
    input  logic                      flip,
    input  logic                      mode,
    output logic                      out_a,
    output logic                      out_b,
    output logic                      busy
);

    localparam int TMR_W = $clog2(STEP_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_DIV - 1);
    localparam int SUM_W = ((ACC_W > SCALED_W) ? ACC_W : SCALED_W) + 2;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((longint'(1) <<< (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;

    // Magnitude is shifted before the sign is reapplied, so truncation is toward zero.
    function automatic logic signed [SCALED_W-1:0] scale_delta(
        input logic signed [DELTA_W-1:0] d,
        input logic [1:0]                spd,
        input logic                      inv
    );
        logic [DELTA_W:0]    mag;
        logic [SCALED_W-1:0] shifted;
        mag = d[DELTA_W-1] ? ((DELTA_W+1)'(0) - {1'b1, d}) : {1'b0, d};
        case (spd)
            SPEED_QTR:  shifted = SCALED_W'(mag >> 2);
            SPEED_HALF: shifted = SCALED_W'(mag >> 1);
            SPEED_X1:   shifted = SCALED_W'(mag);
            default:    shifted = SCALED_W'({mag, 1'b0});
        endcase
        return (d[DELTA_W-1] ^ inv) ? -$signed(shifted) : $signed(shifted);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI)
            return ACC_W'(SAT_HI);
        else if (v < SAT_LO)
            return ACC_W'(SAT_LO);
        else
            return ACC_W'(v);
    endfunction

    logic signed [ACC_W-1:0]    acc_p1;
    logic [TMR_W-1:0]           tmr_p1;
    logic [1:0]                 phase_p1;
    logic                       dir_p1;

    logic                       vld_p0;
    logic signed [SCALED_W-1:0] scaled_p0;
    logic signed [SUM_W-1:0]    add_p0;
    logic signed [SUM_W-1:0]    sum_p0;
    logic                       nz_p0;
    logic                       neg_p0;
    logic                       step_p0;
    logic signed [ACC_W-1:0]    acc_nxt;
    logic [TMR_W-1:0]           tmr_nxt;
    logic [1:0]                 phase_nxt;
    logic                       dir_nxt;
    logic [1:0]                 ab_nxt;
    logic                       a_nxt;
    logic                       b_nxt;

    // Stage p0: scale, step decision and next accumulator/phase
    always_comb begin
        vld_p0    = delta_valid;
        scaled_p0 = vld_p0 ? scale_delta(delta, speed, flip) : '0;
        add_p0    = SUM_W'(acc_p1) + SUM_W'(scaled_p0);
        nz_p0     = (acc_p1 != '0);
        neg_p0    = acc_p1[ACC_W-1];
        // A delta that cancels the accumulator swallows the step due this cycle.
        step_p0   = nz_p0 && (tmr_p1 == TMR_LAST) && (add_p0 != '0);

        sum_p0 = add_p0;
        if (step_p0)
            sum_p0 = neg_p0 ? add_p0 + SUM_W'(1) : add_p0 - SUM_W'(1);
        acc_nxt = sat_acc(sum_p0);

        tmr_nxt = (!nz_p0 || (acc_nxt == '0) || step_p0) ? '0 : tmr_p1 + TMR_W'(1);

        phase_nxt = phase_p1;
        dir_nxt   = dir_p1;
        if (step_p0) begin
            phase_nxt = neg_p0 ? phase_p1 - 2'd1 : phase_p1 + 2'd1;
            dir_nxt   = neg_p0;
        end

        ab_nxt = quad_ab(phase_nxt);
        a_nxt  = (mode == MODE_QUAD) ? ab_nxt[1] : dir_nxt;
        b_nxt  = (mode == MODE_QUAD) ? ab_nxt[0] : phase_nxt[0];
    end

    // Stage p1: state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p1   <= '0;
            tmr_p1   <= '0;
            phase_p1 <= '0;
            dir_p1   <= 1'b0;
            out_a    <= 1'b0;
            out_b    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            acc_p1   <= acc_nxt;
            tmr_p1   <= tmr_nxt;
            phase_p1 <= phase_nxt;
            dir_p1   <= dir_nxt;
            out_a    <= a_nxt;
            out_b    <= b_nxt;
            busy     <= (acc_nxt != '0);
        end
    end

endmodule

// File: rtl/trackball_quad.sv
// Multi-axis trackball motion emulator: AXES independent axes sharing one
// delta strobe, speed setting and output mode.
module trackball_quad
    import trackball_pkg::*;
#(
    parameter int AXES     = 2,
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 3000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    delta_valid,
    input  logic [DELTA_W*AXES-1:0] delta,
    input  logic [1:0]              speed,
    input  logic [AXES-1:0]         flip,
    input  logic                    mode,
    output logic [AXES-1:0]         out_a,
    output logic [AXES-1:0]         out_b,
    output logic [AXES-1:0]         busy
);

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        trackball_axis #(
            .ACC_W    (ACC_W),
            .STEP_DIV (STEP_DIV)
        ) u_axis (
            .clk         (clk),
            .reset       (reset),
            .delta_valid (delta_valid),
            .delta       (delta[DELTA_W*i +: DELTA_W]),
            .speed       (speed),
            .flip        (flip[i]),
            .mode        (mode),
            .out_a       (out_a[i]),
            .out_b       (out_b[i]),
            .busy        (busy[i])
        );
    end

endmodule

// File: tb/tb_trackball_quad.sv
// Scoreboard bench for trackball_quad: stimulus queues expected output
// changes with their cycle stamps; a monitor pops one per observed change.
module tb_trackball_quad;

    localparam int AXES     = 2;
    localparam int ACC_W    = 6;
    localparam int STEP_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        delta_valid = 1'b0;
    logic [17:0] delta = '0;
    logic [1:0]  speed = 2'd2;
    logic [1:0]  flip = 2'b00;
    logic        mode = 1'b0;
    logic [1:0]  out_a;
    logic [1:0]  out_b;
    logic [1:0]  busy;

    trackball_quad #(
        .AXES     (AXES),
        .ACC_W    (ACC_W),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .delta_valid (delta_valid),
        .delta       (delta),
        .speed       (speed),
        .flip        (flip),
        .mode        (mode),
        .out_a       (out_a),
        .out_b       (out_b),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [5:0] obs;
        int         at;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] prev = '0;
    logic [5:0] mon_obs;
    exp_t       mon_e;

    // Observed word is {busy[1:0], out_a[1:0], out_b[1:0]}.
    always @(negedge clk) begin
        mon_obs = {busy, out_a, out_b};
        if (reset) begin
            prev = mon_obs;
        end else if (mon_obs !== prev) begin
            prev = mon_obs;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: got obs=%b at cyc=%0d, required no change", mon_obs, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_obs !== mon_e.obs || cyc != mon_e.at) begin
                    n_bad++;
                    $display("FAIL %s: got obs=%b cyc=%0d, required obs=%b cyc=%0d",
                             mon_e.name, mon_obs, cyc, mon_e.obs, mon_e.at);
                end
            end
        end
    end

    function automatic logic [17:0] dl(input int d0, input int d1);
        logic [8:0] a;
        logic [8:0] b;
        a = d0[8:0];
        b = d1[8:0];
        return {b, a};
    endfunction

    task automatic expect_ev(input string nm, input logic [1:0] bz, input logic [1:0] a,
                             input logic [1:0] b, input int at);
        exp_t e;
        e.name = nm;
        e.obs  = {bz, a, b};
        e.at   = at;
        sb_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", nm, got, want);
        end
    endtask

    // Presents one delta for a single cycle; e0 is the cycle stamp of the capturing edge.
    task automatic send(input logic [17:0] d, output int e0);
        @(posedge clk);
        #1;
        delta       = d;
        delta_valid = 1'b1;
        @(posedge clk);
        #1;
        e0          = cyc;
        delta_valid = 1'b0;
        delta       = '0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d expected changes still pending, required 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int         e0;
        int         e1;
        int         em;
        logic [1:0] gray [4];
        gray[0] = 2'b00;
        gray[1] = 2'b01;
        gray[2] = 2'b11;
        gray[3] = 2'b10;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", {busy, out_a, out_b}, 6'b0);

        // +3 at x1 in quadrature: three forward Gray steps four cycles apart.
        mode  = 1'b1;
        speed = 2'd2;
        send(dl(3, 0), e0);
        expect_ev("fwd_busy",  2'b01, 2'b00, 2'b00, e0);
        expect_ev("fwd_step1", 2'b01, 2'b00, 2'b01, e0 + 4);
        expect_ev("fwd_step2", 2'b01, 2'b01, 2'b01, e0 + 8);
        expect_ev("fwd_step3", 2'b00, 2'b01, 2'b00, e0 + 12);
        drain("fwd", 40);
        pulse_reset();

        // -5 at x0.25 -> -1: one reverse step to phase 3.
        speed = 2'd0;
        send(dl(-5, 0), e0);
        expect_ev("rev_busy", 2'b01, 2'b00, 2'b00, e0);
        expect_ev("rev_step", 2'b00, 2'b01, 2'b00, e0 + 4);
        drain("rev", 40);
        pulse_reset();

        // x0.5 on both axes: +7 -> 3 forward, -9 -> -4 reverse through phase 0.
        speed = 2'd1;
        send(dl(7, -9), e0);
        expect_ev("dual_busy",  2'b11, 2'b00, 2'b00, e0);
        expect_ev("dual_step1", 2'b11, 2'b10, 2'b01, e0 + 4);
        expect_ev("dual_step2", 2'b11, 2'b11, 2'b11, e0 + 8);
        expect_ev("dual_step3", 2'b10, 2'b01, 2'b10, e0 + 12);
        expect_ev("dual_step4", 2'b00, 2'b01, 2'b00, e0 + 16);
        drain("dual", 60);
        pulse_reset();

        // +255 at x2 twice: saturates at +31 and then drains in exactly 31 steps.
        speed = 2'd3;
        send(dl(255, 0), e0);
        expect_ev("sat_busy", 2'b01, 2'b00, 2'b00, e0);
        send(dl(255, 0), e1);
        for (int k = 1; k <= 31; k++)
            expect_ev($sformatf("sat_step%0d", k), (k < 31) ? 2'b01 : 2'b00,
                      {1'b0, gray[k % 4][1]}, {1'b0, gray[k % 4][0]}, e0 + 4 * k);
        drain("sat", 200);
        pulse_reset();

        // +2 then -2 landing on the step cycle: accumulator cancels, no step edge.
        speed = 2'd2;
        send(dl(2, 0), e0);
        expect_ev("cancel_busy", 2'b01, 2'b00, 2'b00, e0);
        expect_ev("cancel_idle", 2'b00, 2'b00, 2'b00, e0 + 4);
        repeat (3) @(posedge clk);
        #1;
        delta       = dl(-2, 0);
        delta_valid = 1'b1;
        @(posedge clk);
        #1;
        delta_valid = 1'b0;
        delta       = '0;
        drain("cancel", 40);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("cancel_quiet", {busy, out_a, out_b}, 6'b0);
        pulse_reset();

        // Clock/direction with axis1 flipped: +2 becomes two negative steps.
        mode = 1'b0;
        flip = 2'b10;
        send(dl(0, 2), e0);
        expect_ev("cd_busy",  2'b10, 2'b00, 2'b00, e0);
        expect_ev("cd_step1", 2'b10, 2'b10, 2'b10, e0 + 4);
        expect_ev("cd_step2", 2'b00, 2'b10, 2'b00, e0 + 8);
        drain("cd", 40);

        // Mode switches keep the phase (axis1 at phase 2, last direction negative).
        @(posedge clk);
        #1 em = cyc;
        expect_ev("mode_to_quad", 2'b00, 2'b10, 2'b10, em + 1);
        mode = 1'b1;
        drain("mode_q", 10);
        @(posedge clk);
        #1 em = cyc;
        expect_ev("mode_to_cd", 2'b00, 2'b10, 2'b00, em + 1);
        mode = 1'b0;
        drain("mode_cd", 10);
        pulse_reset();

        // Reset in the middle of a +10 move: outputs clear at once, no residual steps.
        flip = 2'b00;
        mode = 1'b1;
        send(dl(10, 0), e0);
        expect_ev("rst_busy",  2'b01, 2'b00, 2'b00, e0);
        expect_ev("rst_step1", 2'b01, 2'b00, 2'b01, e0 + 4);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_immediate", {busy, out_a, out_b}, 6'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3 * STEP_DIV + 4) @(posedge clk);
        drain("rst", 5);
        check("rst_quiet", {busy, out_a, out_b}, 6'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
